// File: rtl/dm_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_access_arbiter
// Purpose  : Shares the single data-memory port between the MEM pipeline
//            stage and a loader/debug port. Stalls the pipeline until the
//            MEM-stage access completes, runs a req/ack handshake toward a
//            variable-latency memory, forces the loader through after a run
//            of MEM wins, and aborts accesses whose ack never arrives.
// Revision : 1.0 - initial release
// ============================================================================
module dm_access_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  // MEM stage (from EX/MEM register)
  input  logic              MEM_DM_WE,
  input  logic              MEM_DM_RE,
  input  logic [ADDR_W-1:0] MEM_DM_ADDR,
  input  logic [DATA_W-1:0] MEM_WDATA,
  output logic [DATA_W-1:0] MEM_RDATA,
  output logic              PIPE_STALL,
  // loader / debug port
  input  logic              LD_REQ,
  input  logic              LD_WE,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0] LD_WDATA,
  output logic [DATA_W-1:0] LD_RDATA,
  output logic              LD_DONE,
  // data-memory port
  output logic              DM_REQ,
  output logic              DM_WE,
  output logic [ADDR_W-1:0] DM_ADDR,
  output logic [DATA_W-1:0] DM_WDATA,
  input  logic [DATA_W-1:0] DM_RDATA,
  input  logic              DM_ACK,
  output logic              TIMEOUT_ERR
);

  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);
  localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEM_ACC  = 3'd1,
    S_MEM_DONE = 3'd2,
    S_LD_ACC   = 3'd3,
    S_LD_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [STV_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                dm_req_q, dm_req_d;
  logic                dm_we_q, dm_we_d;
  logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic [DATA_W-1:0]   ld_rdata_q, ld_rdata_d;
  logic                timeout_err_q, timeout_err_d;

  logic mem_req;
  logic grant_mem;
  logic grant_ld;
  logic acc_ld;

  // A store wins over a load when both enables are set; dm_we picks that up.
  assign mem_req = MEM_DM_WE | MEM_DM_RE;

  // Next-state, grant and datapath-register update logic.
  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    dm_req_d      = dm_req_q;
    dm_we_d       = dm_we_q;
    dm_addr_d     = dm_addr_q;
    dm_wdata_d    = dm_wdata_q;
    mem_rdata_d   = mem_rdata_q;
    ld_rdata_d    = ld_rdata_q;
    timeout_err_d = 1'b0;
    grant_mem     = 1'b0;
    grant_ld      = 1'b0;
    acc_ld        = (state_q == S_LD_ACC);

    case (state_q)
      S_IDLE: begin
        tmo_cnt_d = '0;
        if (mem_req && LD_REQ) begin
          if (starve_cnt_q == STARVE_MAX) begin
            grant_ld = 1'b1;
          end else begin
            grant_mem    = 1'b1;
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (mem_req) begin
          grant_mem = 1'b1;
        end else if (LD_REQ) begin
          grant_ld = 1'b1;
        end

        if (grant_mem) begin
          state_d    = S_MEM_ACC;
          dm_req_d   = 1'b1;
          dm_we_d    = MEM_DM_WE;
          dm_addr_d  = MEM_DM_ADDR;
          dm_wdata_d = MEM_WDATA;
        end else if (grant_ld) begin
          state_d      = S_LD_ACC;
          starve_cnt_d = '0;
          dm_req_d     = 1'b1;
          dm_we_d      = LD_WE;
          dm_addr_d    = LD_ADDR;
          dm_wdata_d   = LD_WDATA;
        end
      end

      S_MEM_ACC, S_LD_ACC: begin
        if (DM_ACK) begin
          dm_req_d = 1'b0;
          if (!dm_we_q) begin
            if (acc_ld) ld_rdata_d  = DM_RDATA;
            else        mem_rdata_d = DM_RDATA;
          end
          state_d = acc_ld ? S_LD_DONE : S_MEM_DONE;
        end else if (tmo_cnt_q == TMO_MAX) begin
          // Lost ack: abandon the access and hand back zero for reads.
          dm_req_d      = 1'b0;
          timeout_err_d = 1'b1;
          if (!dm_we_q) begin
            if (acc_ld) ld_rdata_d  = '0;
            else        mem_rdata_d = '0;
          end
          state_d = acc_ld ? S_LD_DONE : S_MEM_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      S_MEM_DONE, S_LD_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      starve_cnt_q  <= '0;
      tmo_cnt_q     <= '0;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= '0;
      dm_wdata_q    <= '0;
      mem_rdata_q   <= '0;
      ld_rdata_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      dm_req_q      <= dm_req_d;
      dm_we_q       <= dm_we_d;
      dm_addr_q     <= dm_addr_d;
      dm_wdata_q    <= dm_wdata_d;
      mem_rdata_q   <= mem_rdata_d;
      ld_rdata_q    <= ld_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // The stall is released only in MEM_DONE, even while the loader owns the port.
  assign PIPE_STALL  = mem_req & (state_q != S_MEM_DONE);
  assign LD_DONE     = (state_q == S_LD_DONE);
  assign DM_REQ      = dm_req_q;
  assign DM_WE       = dm_we_q;
  assign DM_ADDR     = dm_addr_q;
  assign DM_WDATA    = dm_wdata_q;
  assign MEM_RDATA   = mem_rdata_q;
  assign LD_RDATA    = ld_rdata_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_access_arbiter
// Purpose  : Directed self-checking bench for dm_access_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEM_DM_WE, MEM_DM_RE;
  logic [15:0] MEM_DM_ADDR;
  logic [31:0] MEM_WDATA, MEM_RDATA;
  logic        PIPE_STALL;
  logic        LD_REQ, LD_WE;
  logic [15:0] LD_ADDR;
  logic [31:0] LD_WDATA, LD_RDATA;
  logic        LD_DONE;
  logic        DM_REQ, DM_WE;
  logic [15:0] DM_ADDR;
  logic [31:0] DM_WDATA, DM_RDATA;
  logic        DM_ACK;
  logic        TIMEOUT_ERR;

  int checks = 0;
  int errors = 0;

  dm_access_arbiter #(
    .ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_DM_WE(MEM_DM_WE), .MEM_DM_RE(MEM_DM_RE),
    .MEM_DM_ADDR(MEM_DM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .PIPE_STALL(PIPE_STALL),
    .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR),
    .LD_WDATA(LD_WDATA), .LD_RDATA(LD_RDATA), .LD_DONE(LD_DONE),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR),
    .DM_WDATA(DM_WDATA), .DM_RDATA(DM_RDATA), .DM_ACK(DM_ACK),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp_addr [6];
  logic        exp_ld   [6];

  initial begin
    rst_n = 1'b0; MEM_DM_WE = 0; MEM_DM_RE = 0; MEM_DM_ADDR = '0; MEM_WDATA = '0;
    LD_REQ = 0; LD_WE = 0; LD_ADDR = '0; LD_WDATA = '0; DM_RDATA = '0; DM_ACK = 0;

    // ---------------- reset state ----------------
    step(); step();
    chk("rst_dm_req", {31'd0, DM_REQ}, 32'd0);
    chk("rst_dm_addr", {16'd0, DM_ADDR}, 32'd0);
    chk("rst_mem_rdata", MEM_RDATA, 32'd0);
    chk("rst_ld_done", {31'd0, LD_DONE}, 32'd0);
    chk("rst_tmo_err", {31'd0, TIMEOUT_ERR}, 32'd0);
    rst_n = 1'b1;
    step();

    // ---------------- load, same-cycle ack ----------------
    MEM_DM_RE = 1; MEM_DM_ADDR = 16'h0010; #1;
    chk("ld0_stall_idle", {31'd0, PIPE_STALL}, 32'd1);
    step();                                        // MEM_ACC
    chk("ld0_dm_req", {31'd0, DM_REQ}, 32'd1);
    chk("ld0_dm_addr", {16'd0, DM_ADDR}, 32'h0010);
    chk("ld0_dm_we", {31'd0, DM_WE}, 32'd0);
    chk("ld0_stall_acc", {31'd0, PIPE_STALL}, 32'd1);
    DM_ACK = 1; DM_RDATA = 32'hDEADBEEF;
    step();                                        // MEM_DONE
    DM_ACK = 0; #1;
    chk("ld0_stall_done", {31'd0, PIPE_STALL}, 32'd0);
    chk("ld0_rdata", MEM_RDATA, 32'hDEADBEEF);
    chk("ld0_req_drop", {31'd0, DM_REQ}, 32'd0);
    MEM_DM_RE = 0;
    step();                                        // IDLE
    chk("ld0_idle_req", {31'd0, DM_REQ}, 32'd0);

    // ---------------- store, ack after 3 extra cycles ----------------
    MEM_DM_WE = 1; MEM_DM_ADDR = 16'h0020; MEM_WDATA = 32'h12345678; #1;
    chk("st_stall_idle", {31'd0, PIPE_STALL}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();                                      // MEM_ACC cycles 1..4
      chk("st_dm_req", {31'd0, DM_REQ}, 32'd1);
      chk("st_dm_we", {31'd0, DM_WE}, 32'd1);
      chk("st_dm_addr", {16'd0, DM_ADDR}, 32'h0020);
      chk("st_dm_wdata", DM_WDATA, 32'h12345678);
      chk("st_stall_acc", {31'd0, PIPE_STALL}, 32'd1);
      if (k == 3) begin DM_ACK = 1; DM_RDATA = 32'h99999999; end
    end
    step();                                        // MEM_DONE
    DM_ACK = 0; #1;
    chk("st_stall_done", {31'd0, PIPE_STALL}, 32'd0);
    chk("st_rdata_hold", MEM_RDATA, 32'hDEADBEEF);
    chk("st_req_drop", {31'd0, DM_REQ}, 32'd0);
    MEM_DM_WE = 0;
    step();                                        // IDLE

    // ---------------- contention, STARVE_LIMIT=4 ----------------
    exp_addr[0] = 16'h0030; exp_ld[0] = 0;
    exp_addr[1] = 16'h0030; exp_ld[1] = 0;
    exp_addr[2] = 16'h0030; exp_ld[2] = 0;
    exp_addr[3] = 16'h0030; exp_ld[3] = 0;
    exp_addr[4] = 16'h0100; exp_ld[4] = 1;
    exp_addr[5] = 16'h0030; exp_ld[5] = 0;
    MEM_DM_RE = 1; MEM_DM_ADDR = 16'h0030;
    LD_REQ = 1; LD_WE = 0; LD_ADDR = 16'h0100;
    for (int i = 0; i < 6; i++) begin
      step();                                      // ACC
      chk("ct_grant_addr", {16'd0, DM_ADDR}, {16'd0, exp_addr[i]});
      chk("ct_dm_req", {31'd0, DM_REQ}, 32'd1);
      chk("ct_stall_acc", {31'd0, PIPE_STALL}, 32'd1);
      chk("ct_ld_done_acc", {31'd0, LD_DONE}, 32'd0);
      DM_ACK = 1; DM_RDATA = 32'hA0000000 + i;
      step();                                      // DONE
      DM_ACK = 0;
      chk("ct_ld_done", {31'd0, LD_DONE}, {31'd0, exp_ld[i]});
      chk("ct_stall_done", {31'd0, PIPE_STALL}, exp_ld[i] ? 32'd1 : 32'd0);
      if (exp_ld[i]) begin
        chk("ct_ld_rdata", LD_RDATA, 32'hA0000004);
        LD_REQ = 0;
      end else begin
        chk("ct_mem_rdata", MEM_RDATA, 32'hA0000000 + i);
      end
      if (i == 5) MEM_DM_RE = 0;
      step();                                      // IDLE
      chk("ct_idle_ld_done", {31'd0, LD_DONE}, 32'd0);
      chk("ct_idle_req", {31'd0, DM_REQ}, 32'd0);
    end

    // ---------------- lost ack timeout ----------------
    MEM_DM_RE = 1; MEM_DM_ADDR = 16'h0040;
    step();                                        // MEM_ACC, first cycle
    for (int k = 0; k < 64; k++) begin
      chk("to_req_held", {31'd0, DM_REQ}, 32'd1);
      chk("to_no_err", {31'd0, TIMEOUT_ERR}, 32'd0);
      step();
    end
    // now in MEM_DONE
    chk("to_req_drop", {31'd0, DM_REQ}, 32'd0);
    chk("to_err_pulse", {31'd0, TIMEOUT_ERR}, 32'd1);
    chk("to_rdata_zero", MEM_RDATA, 32'd0);
    chk("to_stall_done", {31'd0, PIPE_STALL}, 32'd0);
    MEM_DM_RE = 0;
    step();                                        // IDLE
    chk("to_err_clear", {31'd0, TIMEOUT_ERR}, 32'd0);

    // ---------------- reset during loader access ----------------
    LD_REQ = 1; LD_WE = 1; LD_ADDR = 16'h0200; LD_WDATA = 32'h000055AA;
    step();                                        // LD_ACC
    chk("rl_dm_req", {31'd0, DM_REQ}, 32'd1);
    chk("rl_dm_we", {31'd0, DM_WE}, 32'd1);
    chk("rl_dm_wdata", DM_WDATA, 32'h000055AA);
    rst_n = 0;
    step();                                        // reset applied
    chk("rl_rst_req", {31'd0, DM_REQ}, 32'd0);
    chk("rl_rst_we", {31'd0, DM_WE}, 32'd0);
    chk("rl_rst_addr", {16'd0, DM_ADDR}, 32'd0);
    chk("rl_rst_wdata", DM_WDATA, 32'd0);
    chk("rl_rst_ld_rdata", LD_RDATA, 32'd0);
    chk("rl_rst_ld_done", {31'd0, LD_DONE}, 32'd0);
    rst_n = 1; LD_REQ = 0;
    step();                                        // first cycle after release
    DM_ACK = 1; DM_RDATA = 32'hFFFFFFFF;
    step();
    DM_ACK = 0;
    chk("rl_ack_ign_done", {31'd0, LD_DONE}, 32'd0);
    chk("rl_ack_ign_req", {31'd0, DM_REQ}, 32'd0);
    chk("rl_ack_ign_ldr", LD_RDATA, 32'd0);
    chk("rl_ack_ign_memr", MEM_RDATA, 32'd0);
    step();
    chk("rl_ack_ign_done2", {31'd0, LD_DONE}, 32'd0);

    // ---------------- simultaneous WE and RE ----------------
    MEM_DM_RE = 1; MEM_DM_ADDR = 16'h0050;
    step();                                        // MEM_ACC
    DM_ACK = 1; DM_RDATA = 32'h0BADF00D;
    step();                                        // MEM_DONE
    DM_ACK = 0;
    chk("wr_pre_rdata", MEM_RDATA, 32'h0BADF00D);
    MEM_DM_RE = 0;
    step();                                        // IDLE
    MEM_DM_WE = 1; MEM_DM_RE = 1; MEM_DM_ADDR = 16'h0060; MEM_WDATA = 32'hCAFE0001;
    step();                                        // MEM_ACC
    chk("wr_dm_we", {31'd0, DM_WE}, 32'd1);
    chk("wr_dm_addr", {16'd0, DM_ADDR}, 32'h0060);
    chk("wr_dm_wdata", DM_WDATA, 32'hCAFE0001);
    DM_ACK = 1; DM_RDATA = 32'h11111111;
    step();                                        // MEM_DONE
    DM_ACK = 0; #1;
    chk("wr_rdata_hold", MEM_RDATA, 32'h0BADF00D);
    chk("wr_stall_done", {31'd0, PIPE_STALL}, 32'd0);
    MEM_DM_WE = 0; MEM_DM_RE = 0;
    step();
    chk("wr_idle_req", {31'd0, DM_REQ}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
